// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_THRU,
    ST_REFILL_REQ,
    ST_REFILL_DATA
  } dcache_state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_SETS           = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Extract a bit field [lsb +: width] from a (zero-extended) byte address.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  // Clear the low offset bits so the address points at the start of its line.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int low_bits);
    return addr & ~((32'd1 << low_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the data cache controller.
interface dcache_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [DATA_WIDTH-1:0]   cpu_wdata;
  logic [DATA_WIDTH/8-1:0] cpu_be;
  logic                    flush;
  logic [DATA_WIDTH-1:0]   cpu_rdata;
  logic                    stall;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_ready;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // master: the cache controller (bus master towards main memory)
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, flush,
    input  mem_ready, mem_rvalid, mem_rdata,
    output cpu_rdata, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // slave: pipeline plus main memory surrounding the controller
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, flush,
    output mem_ready, mem_rvalid, mem_rdata,
    input  cpu_rdata, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dcache_tag_array.sv
// Valid bits and tags per line: combinational lookup, one write port, bulk invalidate.
module dcache_tag_array #(
  parameter int SETS    = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               wr_valid_i,
  input  logic               inval_all_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];

  // Bulk invalidate wins over a same-cycle single-line write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inval_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int SETS           = DEF_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                clk,
  input  logic                rst_n,
  dcache_controller_if.master bus
);

  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int BOFF_W  = $clog2(BE_W);
  localparam int WOFF_W  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_WIDTH - BOFF_W - WOFF_W - INDEX_W;
  localparam int DIDX_W  = INDEX_W + WOFF_W;

  dcache_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [WOFF_W-1:0]     cnt_q, cnt_d;

  logic [WOFF_W-1:0]  cpu_word, q_word;
  logic [INDEX_W-1:0] cpu_index, q_index;
  logic [TAG_W-1:0]   cpu_tag, q_tag;

  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic               hit;
  logic               tag_we, tag_wvalid, inval_all;

  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0] rd_word, merged_word, data_wdata;
  logic [DIDX_W-1:0]     data_widx;
  logic                  data_we;
  logic                  stall_raw;

  assign cpu_word  = WOFF_W'(addr_field(32'(bus.cpu_addr), BOFF_W, WOFF_W));
  assign cpu_index = INDEX_W'(addr_field(32'(bus.cpu_addr), BOFF_W + WOFF_W, INDEX_W));
  assign cpu_tag   = TAG_W'(addr_field(32'(bus.cpu_addr), BOFF_W + WOFF_W + INDEX_W, TAG_W));
  assign q_word    = WOFF_W'(addr_field(32'(addr_q), BOFF_W, WOFF_W));
  assign q_index   = INDEX_W'(addr_field(32'(addr_q), BOFF_W + WOFF_W, INDEX_W));
  assign q_tag     = TAG_W'(addr_field(32'(addr_q), BOFF_W + WOFF_W + INDEX_W, TAG_W));

  dcache_tag_array #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tags (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index_i  (cpu_index),
    .rd_valid_o  (line_valid),
    .rd_tag_o    (line_tag),
    .we_i        (tag_we),
    .wr_index_i  (q_index),
    .wr_tag_i    (q_tag),
    .wr_valid_i  (tag_wvalid),
    .inval_all_i (inval_all)
  );

  assign hit     = bus.cpu_req & line_valid & (line_tag == cpu_tag);
  assign rd_word = data_q[{cpu_index, cpu_word}];

  // Byte-lane merge of the pending store into the currently cached word.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
    assign merged_word[gi*8 +: 8] = be_q[gi] ? wdata_q[gi*8 +: 8] : rd_word[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[data_widx] <= data_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    cnt_d         = cnt_q;
    stall_raw     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    tag_we        = 1'b0;
    tag_wvalid    = 1'b0;
    inval_all     = 1'b0;
    data_we       = 1'b0;
    data_widx     = {q_index, q_word};
    data_wdata    = merged_word;

    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          inval_all = 1'b1;
          stall_raw = bus.cpu_req;
        end else if (bus.cpu_req && bus.cpu_we) begin
          stall_raw = 1'b1;
          addr_d    = bus.cpu_addr;
          wdata_d   = bus.cpu_wdata;
          be_d      = bus.cpu_be;
          state_d   = ST_WRITE_THRU;
        end else if (bus.cpu_req && !hit) begin
          stall_raw = 1'b1;
          addr_d    = bus.cpu_addr;
          state_d   = ST_REFILL_REQ;
        end
      end

      ST_WRITE_THRU: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_be    = be_q;
        stall_raw     = ~bus.mem_ready;
        if (bus.mem_ready) begin
          data_we = hit;
          state_d = ST_IDLE;
        end
      end

      ST_REFILL_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = ADDR_WIDTH'(line_base(32'(addr_q), BOFF_W + WOFF_W));
        stall_raw    = 1'b1;
        // Drop the victim line before its words get overwritten beat by beat.
        if (bus.mem_ready) begin
          tag_we  = 1'b1;
          cnt_d   = '0;
          state_d = ST_REFILL_DATA;
        end
      end

      ST_REFILL_DATA: begin
        stall_raw  = 1'b1;
        data_widx  = {q_index, cnt_q};
        data_wdata = bus.mem_rdata;
        if (bus.mem_rvalid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + WOFF_W'(1);
          if (cnt_q == WOFF_W'(WORDS_PER_LINE - 1)) begin
            tag_we     = 1'b1;
            tag_wvalid = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Held low throughout reset even if the pipeline still presents a request.
  assign bus.stall     = stall_raw & rst_n;
  assign bus.cpu_rdata = hit ? rd_word : '0;

endmodule
